// File: rtl/mvm_pkg.sv
// Shared definitions for the MVM sequencing controller.
//   state_e       : controller FSM states
//   calc_w_bus_kx : width of the assembled {k, x} bus
//   calc_w_bus_y  : width of the result bus
//   calc_n_words  : number of serial words needed to cover a bus
//   cnt_w         : counter width able to index n words (at least 1 bit)
package mvm_pkg;

  typedef enum logic [1:0] {
    ST_RECV   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT_Y = 2'd2,
    ST_SEND   = 2'd3
  } state_e;

  function automatic int calc_w_bus_kx(int r, int c, int w_k, int w_x);
    return r * c * w_k + c * w_x;
  endfunction

  function automatic int calc_w_bus_y(int r, int w_y_out);
    return r * w_y_out;
  endfunction

  function automatic int calc_n_words(int w_bus, int bits_per_word);
    return w_bus / bits_per_word;
  endfunction

  function automatic int cnt_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mvm_seq_ctrl_if.sv
// Handshake/bus bundle around the MVM sequencing controller.
//   s_valid/s_data                   : words from the UART receiver (no backpressure)
//   m_kx_valid/m_kx_ready/m_kx_data  : assembled {k, x} bus towards the MVM
//   s_y_valid/s_y_ready/s_y_data     : result bus from the MVM
//   m_tx_valid/m_tx_ready/m_tx_data  : words towards the UART transmitter
// Modport master is the controller's view, slave is the surrounding system's view.
interface mvm_seq_ctrl_if #(
  parameter int BITS_PER_WORD = 8,
  parameter int W_BUS_KX      = 16,
  parameter int W_BUS_Y       = 16
);
  logic                     s_valid;
  logic [BITS_PER_WORD-1:0] s_data;
  logic                     m_kx_valid;
  logic                     m_kx_ready;
  logic [W_BUS_KX-1:0]      m_kx_data;
  logic                     s_y_valid;
  logic                     s_y_ready;
  logic [W_BUS_Y-1:0]       s_y_data;
  logic                     m_tx_valid;
  logic                     m_tx_ready;
  logic [BITS_PER_WORD-1:0] m_tx_data;

  modport master (
    input  s_valid, s_data, m_kx_ready, s_y_valid, s_y_data, m_tx_ready,
    output m_kx_valid, m_kx_data, s_y_ready, m_tx_valid, m_tx_data
  );

  modport slave (
    output s_valid, s_data, m_kx_ready, s_y_valid, s_y_data, m_tx_ready,
    input  m_kx_valid, m_kx_data, s_y_ready, m_tx_valid, m_tx_data
  );
endinterface

// File: rtl/mvm_word_gather.sv
// Word deserializer: writes each accepted word into slot cnt_q of frame_q
// (slot 0 = LSBs) and pulses done combinationally on the last word of a frame.
//   clk, rst  : clock, synchronous active-high reset (clears frame and counter)
//   en        : gathering allowed (controller is in RECV)
//   in_valid  : word strobe
//   in_data   : word
//   frame_q   : assembled frame, held stable while en is low
//   cnt_q     : index of the next slot to be written
//   done      : last word of the frame accepted this cycle
// Optional macro MVM_SEQ_CTRL_TIMEOUT_EN: a partial frame idle for
// TIMEOUT_CYCLES cycles is discarded (counter returns to slot 0).
module mvm_word_gather
  import mvm_pkg::*;
#(
  parameter int BITS_PER_WORD  = 8,
  parameter int N_WORDS        = 2,
  parameter int TIMEOUT_CYCLES = 65535,
  localparam int CW            = cnt_w(N_WORDS),
  localparam int W_FRAME       = N_WORDS * BITS_PER_WORD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     in_valid,
  input  logic [BITS_PER_WORD-1:0] in_data,
  output logic [W_FRAME-1:0]       frame_q,
  output logic [CW-1:0]            cnt_q,
  output logic                     done
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mvm_word_gather: TIMEOUT_CYCLES must be at least 1");
  end

  logic [W_FRAME-1:0] frame_d;
  logic [CW-1:0]      cnt_d;
  logic               timeout;

`ifdef MVM_SEQ_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmr_q, tmr_d;

  // Counts idle cycles of a partially received frame; any word restarts it.
  always_comb begin
    tmr_d   = '0;
    timeout = 1'b0;
    if (en && !in_valid && (cnt_q != '0)) begin
      if (tmr_q == TW'(TIMEOUT_CYCLES - 1)) timeout = 1'b1;
      else                                  tmr_d   = tmr_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) tmr_q <= '0;
    else     tmr_q <= tmr_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    frame_d = frame_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    if (en && in_valid) begin
      frame_d[int'(cnt_q) * BITS_PER_WORD +: BITS_PER_WORD] = in_data;
      if (cnt_q == CW'(N_WORDS - 1)) begin
        cnt_d = '0;
        done  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (timeout) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q <= '0;
      cnt_q   <= '0;
    end else begin
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/mvm_seq_ctrl.sv
// MVM sequencing controller: gathers serial words into the {k, x} bus, hands
// it to the MVM, captures the result bus and streams it back out word by word.
//   clk      : single clock, rising edge
//   rst      : synchronous active-high reset; aborts any frame in flight
//   bus      : mvm_seq_ctrl_if.master (receiver words, KX bus, Y bus, TX words)
//   overrun  : sticky, a word arrived while not in RECV (cleared only by rst)
//   busy     : high except in RECV with no word of a frame received yet
// Optional macro MVM_SEQ_CTRL_TIMEOUT_EN enables discarding of a partial
// frame after TIMEOUT_CYCLES idle cycles.
module mvm_seq_ctrl
  import mvm_pkg::*;
#(
  parameter int R              = 2,
  parameter int C              = 2,
  parameter int W_X            = 4,
  parameter int W_K            = 2,
  parameter int W_Y_OUT        = 8,
  parameter int BITS_PER_WORD  = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic          clk,
  input  logic          rst,
  mvm_seq_ctrl_if.master bus,
  output logic          overrun,
  output logic          busy
);

  localparam int W_BUS_KX   = calc_w_bus_kx(R, C, W_K, W_X);
  localparam int W_BUS_Y    = calc_w_bus_y(R, W_Y_OUT);
  localparam int N_WORDS_KX = calc_n_words(W_BUS_KX, BITS_PER_WORD);
  localparam int N_WORDS_Y  = calc_n_words(W_BUS_Y, BITS_PER_WORD);
  localparam int RCW        = cnt_w(N_WORDS_KX);
  localparam int TCW        = cnt_w(N_WORDS_Y);

  if ((W_BUS_KX % BITS_PER_WORD) != 0) begin : g_bad_kx
    $error("mvm_seq_ctrl: W_BUS_KX is not a multiple of BITS_PER_WORD");
  end
  if ((W_BUS_Y % BITS_PER_WORD) != 0) begin : g_bad_y
    $error("mvm_seq_ctrl: W_BUS_Y is not a multiple of BITS_PER_WORD");
  end

  state_e               state_q, state_d;
  logic [W_BUS_Y-1:0]   y_q, y_d;
  logic [TCW-1:0]       tx_cnt_q, tx_cnt_d;
  logic                 overrun_q, overrun_d;
  logic                 recv_en;
  logic                 frame_done;
  logic [RCW-1:0]       rx_cnt;
  logic [W_BUS_KX-1:0]  kx_buf;

  assign recv_en = (state_q == ST_RECV);

  // The gather buffer only changes in RECV, so it doubles as the stable KX
  // payload for the whole ISSUE handshake.
  mvm_word_gather #(
    .BITS_PER_WORD  (BITS_PER_WORD),
    .N_WORDS        (N_WORDS_KX),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_gather (
    .clk      (clk),
    .rst      (rst),
    .en       (recv_en),
    .in_valid (bus.s_valid),
    .in_data  (bus.s_data),
    .frame_q  (kx_buf),
    .cnt_q    (rx_cnt),
    .done     (frame_done)
  );

  always_comb begin
    state_d        = state_q;
    y_d            = y_q;
    tx_cnt_d       = tx_cnt_q;
    // Words outside RECV are dropped; this includes the final SEND cycle.
    overrun_d      = overrun_q | (bus.s_valid && (state_q != ST_RECV));
    bus.m_kx_valid = 1'b0;
    bus.s_y_ready  = 1'b0;
    bus.m_tx_valid = 1'b0;
    unique case (state_q)
      ST_RECV: begin
        if (frame_done) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        bus.m_kx_valid = 1'b1;
        if (bus.m_kx_ready) state_d = ST_WAIT_Y;
      end
      ST_WAIT_Y: begin
        bus.s_y_ready = 1'b1;
        if (bus.s_y_valid) begin
          y_d     = bus.s_y_data;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        bus.m_tx_valid = 1'b1;
        if (bus.m_tx_ready) begin
          if (tx_cnt_q == TCW'(N_WORDS_Y - 1)) begin
            tx_cnt_d = '0;
            state_d  = ST_RECV;
          end else begin
            tx_cnt_d = tx_cnt_q + TCW'(1);
          end
        end
      end
      default: state_d = ST_RECV;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RECV;
      y_q       <= '0;
      tx_cnt_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      tx_cnt_q  <= tx_cnt_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.m_kx_data = kx_buf;
  assign bus.m_tx_data = y_q[int'(tx_cnt_q) * BITS_PER_WORD +: BITS_PER_WORD];
  assign overrun       = overrun_q;
  assign busy          = (state_q != ST_RECV) || (rx_cnt != '0);

endmodule

// File: tb/tb_mvm_seq_ctrl.sv
// Scoreboard bench for mvm_seq_ctrl: stimulus pushes expected KX buses and TX
// words into queues; a negedge monitor pops and compares on every handshake.
module tb_mvm_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic overrun;
  logic busy;

  int checks   = 0;
  int failures = 0;

  logic [15:0] kx_exp[$];
  logic [7:0]  tx_exp[$];

  mvm_seq_ctrl_if #(.BITS_PER_WORD(8), .W_BUS_KX(16), .W_BUS_Y(16)) if_i ();

  mvm_seq_ctrl #(
    .R(2), .C(2), .W_X(4), .W_K(2), .W_Y_OUT(8),
    .BITS_PER_WORD(8), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (if_i),
    .overrun (overrun),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: every handshake the DUT completes must match the next expectation.
  always @(negedge clk) begin
    if (!rst && if_i.m_kx_valid && if_i.m_kx_ready) begin
      if (kx_exp.size() == 0) begin
        checks++; failures++;
        $display("FAIL kx_unexpected: got 0x%0h expected no transfer", if_i.m_kx_data);
      end else begin
        check("kx_data", 32'(if_i.m_kx_data), 32'(kx_exp.pop_front()));
      end
    end
    if (!rst && if_i.m_tx_valid && if_i.m_tx_ready) begin
      if (tx_exp.size() == 0) begin
        checks++; failures++;
        $display("FAIL tx_unexpected: got 0x%0h expected no transfer", if_i.m_tx_data);
      end else begin
        check("tx_data", 32'(if_i.m_tx_data), 32'(tx_exp.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w);
    if_i.s_valid = 1'b1;
    if_i.s_data  = w;
    tick();
    if_i.s_valid = 1'b0;
  endtask

  task automatic give_y(input logic [15:0] y);
    if_i.s_y_valid = 1'b1;
    if_i.s_y_data  = y;
    tick();
    if_i.s_y_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    if_i.s_valid    = 1'b0;
    if_i.s_data     = '0;
    if_i.m_kx_ready = 1'b1;
    if_i.s_y_valid  = 1'b0;
    if_i.s_y_data   = '0;
    if_i.m_tx_ready = 1'b1;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    check("rst_busy",       32'(busy), 0);
    check("rst_overrun",    32'(overrun), 0);
    check("rst_kx_valid",   32'(if_i.m_kx_valid), 0);
    check("rst_tx_valid",   32'(if_i.m_tx_valid), 0);
    check("rst_y_ready",    32'(if_i.s_y_ready), 0);
    check("rst_kx_data",    32'(if_i.m_kx_data), 0);

    // Basic frame: 0x5A, 0xC3 -> 0xC35A; result 0x12F0 -> F0, 12
    kx_exp.push_back(16'hC35A);
    send_word(8'h5A);
    check("busy_partial", 32'(busy), 1);
    send_word(8'hC3);
    check("kx_valid_lat", 32'(if_i.m_kx_valid), 1);
    tick();
    check("kx_valid_pulse", 32'(if_i.m_kx_valid), 0);
    check("y_ready_wait",   32'(if_i.s_y_ready), 1);
    tx_exp.push_back(8'hF0);
    tx_exp.push_back(8'h12);
    give_y(16'h12F0);
    check("tx_valid_lat", 32'(if_i.m_tx_valid), 1);
    check("y_ready_send", 32'(if_i.s_y_ready), 0);
    tick(); tick();
    check("recv_busy",     32'(busy), 0);
    check("recv_tx_valid", 32'(if_i.m_tx_valid), 0);
    check("no_overrun",    32'(overrun), 0);

    // KX backpressure for 10 cycles, then overrun during WAIT_Y
    if_i.m_kx_ready = 1'b0;
    kx_exp.push_back(16'h2211);
    send_word(8'h11);
    send_word(8'h22);
    for (int i = 0; i < 10; i++) begin
      check("kx_hold_valid", 32'(if_i.m_kx_valid), 1);
      check("kx_hold_data",  32'(if_i.m_kx_data), 32'h2211);
      tick();
    end
    if_i.m_kx_ready = 1'b1;
    tick();
    check("kx_after_hs", 32'(if_i.m_kx_valid), 0);
    check("wait_y_ready", 32'(if_i.s_y_ready), 1);
    send_word(8'h77);
    check("overrun_set",   32'(overrun), 1);
    check("overrun_state", 32'(if_i.s_y_ready), 1);
    tx_exp.push_back(8'hEF);
    tx_exp.push_back(8'hBE);
    give_y(16'hBEEF);
    tick(); tick();
    kx_exp.push_back(16'h4433);
    send_word(8'h33);
    send_word(8'h44);
    tick();
    check("overrun_sticky", 32'(overrun), 1);
    if_i.m_tx_ready = 1'b0;
    tx_exp.push_back(8'h5A);
    tx_exp.push_back(8'hA5);
    give_y(16'hA55A);
    for (int i = 0; i < 3; i++) begin
      check("tx_hold_data", 32'(if_i.m_tx_data), 32'h5A);
      tick();
    end
    if_i.m_tx_ready = 1'b1;
    tick(); tick();
    check("recv_after_stall", 32'(busy), 0);

    // Reset in SEND after word 0
    kx_exp.push_back(16'h0605);
    send_word(8'h05);
    send_word(8'h06);
    tick();
    tx_exp.push_back(8'hCD);
    give_y(16'hABCD);
    tick();
    if_i.m_tx_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_tx_valid", 32'(if_i.m_tx_valid), 0);
    check("mid_rst_kx_valid", 32'(if_i.m_kx_valid), 0);
    check("mid_rst_y_ready",  32'(if_i.s_y_ready), 0);
    check("mid_rst_busy",     32'(busy), 0);
    check("mid_rst_overrun",  32'(overrun), 0);
    check("mid_rst_kx_data",  32'(if_i.m_kx_data), 0);
    if_i.m_tx_ready = 1'b1;
    kx_exp.push_back(16'h0807);
    send_word(8'h07);
    send_word(8'h08);
    tick();
    tx_exp.push_back(8'h12);
    tx_exp.push_back(8'h34);
    give_y(16'h3412);
    tick();
    // Final TX handshake together with an incoming word: the word is dropped
    if_i.s_valid = 1'b1;
    if_i.s_data  = 8'h99;
    tick();
    if_i.s_valid = 1'b0;
    check("final_word_overrun", 32'(overrun), 1);
    check("final_word_dropped", 32'(busy), 0);

`ifdef MVM_SEQ_CTRL_TIMEOUT_EN
    send_word(8'hAA);
    for (int i = 0; i < 15; i++) tick();
    check("timeout_not_yet", 32'(busy), 1);
    tick();
    check("timeout_discard", 32'(busy), 0);
    kx_exp.push_back(16'h0201);
    send_word(8'h01);
    send_word(8'h02);
`else
    send_word(8'hAA);
    for (int i = 0; i < 20; i++) tick();
    check("partial_waits", 32'(busy), 1);
    kx_exp.push_back(16'h01AA);
    send_word(8'h01);
`endif
    tick(); tick();
    check("kx_queue_drained", 32'(kx_exp.size()), 0);
    check("tx_queue_drained", 32'(tx_exp.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
